// File: rtl/sqrt_pkg.sv
// Shared constants for the sqrt_lut datapath and its request arbiter.
// SQRT_LUT_LAT is the single source for the sqrt_lut pipeline depth.
package sqrt_pkg;
    localparam int SQRT_DW_I    = 16;
    localparam int SQRT_DW_O    = 8;
    localparam int SQRT_LUT_LAT = 2;
    localparam int SQRT_NREQ    = 4;

    // Tag width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant over NREQ requesters with a registered pointer.
// Search starts at pointer+1; the pointer moves to the winner on every grant.
module rr_arbiter import sqrt_pkg::*; #(
    parameter int NREQ = SQRT_NREQ,
    parameter int TW   = clog2_min1(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_gnt,
    output logic [TW-1:0]   o_idx,
    output logic            o_vld
);
    logic [TW-1:0] r_ptr;
    logic          w_found;
    int            w_idx;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = (int'(r_ptr) + i) % NREQ;
            if (i_en && !w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_idx        = w_idx[TW-1:0];
                w_found      = 1'b1;
            end
        end
    end

    assign o_vld = w_found;

    // Reset to the last index so requester 0 wins the first arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ptr <= TW'(NREQ - 1);
        else if (w_found)
            r_ptr <= o_idx;
    end
endmodule

// File: rtl/sqrt_lut_arbiter.sv
// Shares one fixed-latency sqrt_lut among NREQ requesters: round-robin issue,
// tag pipeline aligned with the LUT, and registered per-requester result pulses.
module sqrt_lut_arbiter import sqrt_pkg::*; #(
    parameter int NREQ    = SQRT_NREQ,
    parameter int DW_I    = SQRT_DW_I,
    parameter int DW_O    = SQRT_DW_O,
    parameter int LUT_LAT = SQRT_LUT_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic [NREQ-1:0]      req_val_i,
    input  logic [NREQ*DW_I-1:0] req_data_i,
    output logic [NREQ-1:0]      req_rdy_o,
    output logic [NREQ-1:0]      res_val_o,
    output logic [DW_O-1:0]      res_data_o,
    output logic [DW_I-1:0]      lut_in_o,
    output logic                 lut_val_o,
    input  logic [DW_O-1:0]      lut_out_i,
    input  logic                 lut_val_i,
    output logic                 err_o
);
    localparam int TW = clog2_min1(NREQ);
    localparam int FW = $clog2(LUT_LAT + 2);

    logic [FW-1:0]               r_flush_cnt;
    logic [LUT_LAT:0]            r_vld_pipe;
    logic [LUT_LAT:0][TW-1:0]    r_tag_pipe;
    logic [DW_I-1:0]             r_lut_in;
    logic [NREQ-1:0]             r_res_val;
    logic [DW_O-1:0]             r_res_data;
    logic                        r_err;

    logic                        w_flush;
    logic [NREQ-1:0]             w_gnt;
    logic [TW-1:0]               w_gidx;
    logic                        w_xfer;
    logic [DW_I-1:0]             w_op;
    logic                        w_tvld;
    logic [TW-1:0]               w_tag;

    assign w_flush = (r_flush_cnt != '0);

    rr_arbiter #(.NREQ(NREQ), .TW(TW)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_en  (en_i & ~w_flush),
        .i_req (req_val_i),
        .o_gnt (w_gnt),
        .o_idx (w_gidx),
        .o_vld (w_xfer)
    );

    assign w_op = req_data_i[w_gidx*DW_I +: DW_I];

    // The sqrt_lut has no reset, so its pipeline is drained blind after every reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_flush_cnt <= FW'(LUT_LAT + 1);
        else if (w_flush)
            r_flush_cnt <= r_flush_cnt - FW'(1);
    end

    // Stage 0 is the issue register driving the LUT; stage LUT_LAT lines up with lut_val_i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_tag_pipe <= '0;
            r_lut_in   <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[LUT_LAT-1:0], w_xfer};
            r_tag_pipe <= {r_tag_pipe[LUT_LAT-1:0], w_gidx};
            if (w_xfer)
                r_lut_in <= w_op;
        end
    end

    assign w_tvld = r_vld_pipe[LUT_LAT] & ~w_flush;
    assign w_tag  = r_tag_pipe[LUT_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_val  <= '0;
            r_res_data <= '0;
            r_err      <= 1'b0;
        end else begin
            r_res_val <= w_tvld ? ({{(NREQ-1){1'b0}}, 1'b1} << w_tag) : '0;
            if (w_tvld)
                r_res_data <= lut_out_i;
            if (!w_flush && (lut_val_i != r_vld_pipe[LUT_LAT]))
                r_err <= 1'b1;
        end
    end

    assign req_rdy_o  = w_gnt;
    assign lut_in_o   = r_lut_in;
    assign lut_val_o  = r_vld_pipe[0];
    assign res_val_o  = r_res_val;
    assign res_data_o = r_res_data;
    assign err_o      = r_err;
endmodule

// File: tb/tb_sqrt_lut_arbiter.sv
// Bench for sqrt_lut_arbiter with a behavioural floor-sqrt LUT; a scoreboard
// queue collects expected results and an independent monitor checks each pulse.
module tb_sqrt_lut_arbiter;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_i;
    logic [3:0]  req_val_i;
    logic [63:0] req_data_i;
    logic [3:0]  req_rdy_o;
    logic [3:0]  res_val_o;
    logic [7:0]  res_data_o;
    logic [15:0] lut_in_o;
    logic        lut_val_o;
    logic [7:0]  lut_out_i;
    logic        lut_val_i;
    logic        err_o;
    logic        f_spur;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0] ch;
        logic [7:0] data;
        int         due;
    } exp_t;
    exp_t q[$];

    sqrt_lut_arbiter #(.NREQ(4), .DW_I(16), .DW_O(8), .LUT_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en_i),
        .req_val_i  (req_val_i),
        .req_data_i (req_data_i),
        .req_rdy_o  (req_rdy_o),
        .res_val_o  (res_val_o),
        .res_data_o (res_data_o),
        .lut_in_o   (lut_in_o),
        .lut_val_o  (lut_val_o),
        .lut_out_i  (lut_out_i),
        .lut_val_i  (lut_val_i),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the sqrt_lut: floor sqrt, LAT registers deep, no reset.
    function automatic logic [7:0] isqrt(input logic [15:0] x);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(x)) r++;
        return r[7:0];
    endfunction

    logic [LAT-1:0]      m_v;
    logic [LAT-1:0][7:0] m_d;
    always @(posedge clk) begin
        m_v <= {m_v[LAT-2:0], lut_val_o};
        m_d <= {m_d[LAT-2:0], isqrt(lut_in_o)};
    end
    assign lut_val_i = m_v[LAT-1] | f_spur;
    assign lut_out_i = m_d[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus, starting and ending on a falling edge.
    task automatic drv(input logic [3:0] val, input logic [63:0] dat,
                       input logic [3:0] egnt, input logic [7:0] eres, input bit keep = 1'b1);
        exp_t e;
        req_val_i  = val;
        req_data_i = dat;
        #1;
        chk("grant", 64'(req_rdy_o), 64'(egnt));
        if (keep && egnt != 4'd0) begin
            e.ch   = egnt;
            e.data = eres;
            e.due  = cyc + LAT + 2;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        repeat (n) drv(4'd0, 64'd0, 4'd0, 8'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (res_val_o != 4'd0) begin
                if (q.size() == 0) begin
                    chk("res_spurious", 64'(res_val_o), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("res", {20'd0, res_val_o, res_data_o, cyc}, {20'd0, e.ch, e.data, e.due});
                end
            end else if (q.size() != 0 && q[0].due < cyc) begin
                e = q.pop_front();
                chk("res_missing", 64'(cyc), 64'(e.due));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    localparam logic [63:0] D1 = {16'h00E1, 16'h0090, 16'h0031, 16'h0010};
    localparam logic [63:0] D4 = {16'h0064, 16'h0000, 16'h0019, 16'h0000};
    localparam logic [63:0] D5 = {16'h0000, 16'h0024, 16'h0000, 16'h0100};

    initial begin
        rst = 1'b1; en_i = 1'b1; f_spur = 1'b0;
        req_val_i = 4'hF; req_data_i = D1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdy", 64'(req_rdy_o), 64'd0);
        chk("rst_lut_val", 64'(lut_val_o), 64'd0);
        chk("rst_lut_in", 64'(lut_in_o), 64'd0);
        chk("rst_res_val", 64'(res_val_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Flush window, then round-robin from requester 0.
        repeat (LAT + 1) drv(4'hF, D1, 4'd0, 8'd0);
        drv(4'hF, D1, 4'b0001, 8'h04);
        drv(4'hF, D1, 4'b0010, 8'h07);
        drv(4'hF, D1, 4'b0100, 8'h0C);
        drv(4'hF, D1, 4'b1000, 8'h0F);
        drv(4'hF, D1, 4'b0001, 8'h04);
        drain(6);

        // Single request.
        drv(4'b0100, {16'h0000, 16'h0400, 32'd0}, 4'b0100, 8'h20);
        drain(6);

        // Back-to-back stream from one requester, including both data extremes.
        drv(4'b0001, 64'h0000, 4'b0001, 8'h00);
        drv(4'b0001, 64'h0051, 4'b0001, 8'h09);
        drv(4'b0001, 64'hFFFF, 4'b0001, 8'hFF);
        drain(6);

        // Park pointer at 1, then contention between 1 and 3.
        drv(4'b0010, D4, 4'b0010, 8'h05);
        drv(4'b1010, D4, 4'b1000, 8'h0A);
        drv(4'b1010, D4, 4'b0010, 8'h05);
        drv(4'b1010, D4, 4'b1000, 8'h0A);
        drv(4'b1010, D4, 4'b0010, 8'h05);
        drain(6);

        // Enable dropped with two results in flight.
        drv(4'b0101, D5, 4'b0100, 8'h06);
        drv(4'b0101, D5, 4'b0001, 8'h10);
        en_i = 1'b0;
        repeat (3) drv(4'b0101, D5, 4'd0, 8'd0);
        en_i = 1'b1;
        drv(4'b0101, D5, 4'b0100, 8'h06);
        drain(6);

        // Reset with two in flight: those results must never appear.
        drv(4'b1010, D1, 4'b1000, 8'h0F, 1'b0);
        drv(4'b1010, D1, 4'b0010, 8'h07, 1'b0);
        rst = 1'b1;
        req_val_i = 4'd0;
        #1;
        chk("midrst_err", 64'(err_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 1) drv(4'hF, D1, 4'd0, 8'd0);
        drv(4'hF, D1, 4'b0001, 8'h04);
        drain(6);
        chk("err_after_flush", 64'(err_o), 64'd0);

        // Spurious LUT valid sets the sticky error.
        f_spur = 1'b1;
        drv(4'd0, 64'd0, 4'd0, 8'd0);
        f_spur = 1'b0;
        #1;
        chk("err_set", 64'(err_o), 64'd1);
        @(negedge clk);
        drain(3);
        chk("err_sticky", 64'(err_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("err_clear", 64'(err_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drain(2);

        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
